// File: rtl/disp_scheduler.sv
// Disparity sweep scheduler: issues one cost calculation per candidate, keeps the per-block
// running minimum/argmin, then streams the winning disparity of every block. Macro DISP_SCHED_COST_OUT_EN adds out_cost.
module disp_scheduler #(
    parameter int NUM_BLK  = 64,
    parameter int RW       = 18,
    parameter int DW       = 6,
    parameter int CALC_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DW-1:0]         max_disp,
    output logic                  busy,
    output logic                  done,
    output logic                  calc_sig,
    output logic [DW-1:0]         disp_idx,
    input  logic [NUM_BLK*RW-1:0] result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_blk,
    output logic [DW-1:0]         out_disp
`ifdef DISP_SCHED_COST_OUT_EN
    ,
    output logic [RW-1:0]         out_cost
`endif
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCAN, NEXT, OUT, DONE} state_t;

    localparam logic [5:0] LAST_BLK  = 6'(NUM_BLK - 1);
    localparam logic [5:0] LAST_WAIT = 6'(CALC_LAT - 1);

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [DW-1:0] idx_q, idx_d;
    logic [DW-1:0] max_q, max_d;

    logic [RW-1:0] min_q [NUM_BLK];
    logic [DW-1:0] arg_q [NUM_BLK];
    logic [RW-1:0] cost;
    logic          upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
        end
    end

    // cnt_q is reused as wait counter, scan block index and output beat pointer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        max_d   = max_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    max_d   = max_disp;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            SCAN: begin
                if (cnt_q == LAST_BLK) begin
                    cnt_d   = '0;
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            NEXT: begin
                cnt_d = '0;
                if (idx_q == max_q) begin
                    state_d = OUT;
                end else begin
                    idx_d   = idx_q + DW'(1);
                    state_d = ISSUE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (cnt_q == LAST_BLK) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Candidate 0 seeds the table; later candidates replace only on a strictly lower cost.
    assign cost = result[int'(cnt_q)*RW +: RW];
    assign upd  = (state_q == SCAN) && ((idx_q == '0) || (cost < min_q[cnt_q]));

    always_ff @(posedge clk) begin
        if (upd) begin
            min_q[cnt_q] <= cost;
            arg_q[cnt_q] <= idx_q;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign calc_sig  = (state_q == ISSUE);
    assign disp_idx  = idx_q;
    assign out_valid = (state_q == OUT);
    assign out_blk   = out_valid ? cnt_q : '0;
    assign out_disp  = out_valid ? arg_q[cnt_q] : '0;
`ifdef DISP_SCHED_COST_OUT_EN
    assign out_cost  = out_valid ? min_q[cnt_q] : '0;
`endif

endmodule

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter NUM_BLK, default 64, number of 18-bit block costs on the result bus.
REQ-002 Parameter RW, default 18, width of one block cost.
REQ-003 Parameter DW, default 6, width of the disparity index.
REQ-004 Parameter CALC_LAT, default 2, cycles the datapath needs after calc_sig before result is stable (range 1..15).
REQ-005 clk  in  1  single clock for all state; rising edge active.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  level-sampled request to begin one disparity sweep.
REQ-008 max_disp  in  DW  last disparity candidate to evaluate, sampled on accepted start.
REQ-009 busy  out  1  high from accepted start until the done pulse.
REQ-010 done  out  1  one-cycle pulse after the last output beat.
REQ-011 calc_sig  out  1  one-cycle strobe that makes the cost datapath register new results.
REQ-012 disp_idx  out  DW  current disparity candidate driven to the shift/buffer logic.
REQ-013 result  in  NUM_BLK*RW  packed costs from the datapath; block b occupies bits [b*RW+RW-1 : b*RW].
REQ-014 out_valid  out  1  output beat valid.
REQ-015 out_ready  in  1  downstream accepts beat when high with out_valid.
REQ-016 out_blk  out  6  block number of the current beat.
REQ-017 out_disp  out  DW  winning disparity of block out_blk.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, SCAN, NEXT, OUT, DONE.
REQ-019 IDLE: start=1 latches max_disp, clears disp_idx to 0, asserts busy, goes to ISSUE next cycle; start ignored in every other state.
REQ-020 ISSUE: calc_sig=1 for exactly one cycle, then WAIT.
REQ-021 WAIT: counts CALC_LAT cycles, then SCAN; disp_idx held constant from ISSUE through end of SCAN.
REQ-022 SCAN: one block per cycle, b=0..NUM_BLK-1; cost slice b compared as unsigned RW-bit value against stored min[b].
REQ-023 When disp_idx=0, min[b] and arg[b] are written unconditionally; otherwise written only if cost < min[b] (strict, so ties keep the smaller disparity).
REQ-024 NEXT (one cycle): if disp_idx==latched max_disp go to OUT with beat pointer 0, else disp_idx+1 and ISSUE.
REQ-025 Per-candidate cost = 1+CALC_LAT+NUM_BLK+1 cycles; default 68 cycles.
REQ-026 OUT: out_valid=1, out_blk=pointer, out_disp=arg[pointer]; pointer advances only on out_valid&&out_ready; beat held stable while out_ready=0.
REQ-027 After beat NUM_BLK-1 accepted: DONE for one cycle with done=1, busy=0 from the following cycle, then IDLE.
REQ-028 max_disp=0: single candidate, all out_disp=0.
REQ-029 disp_idx never wraps: max_disp=2^DW-1 terminates at that value.
REQ-030 min/arg storage is a 64-entry register array or single-port RAM; one read and one write per SCAN cycle.

Reset
REQ-031 rst_n low forces IDLE asynchronously from any state, including mid-SCAN or mid-OUT; partial sweep discarded.
REQ-032 Reset values: busy=0, done=0, calc_sig=0, disp_idx=0, out_valid=0, out_blk=0, out_disp=0, counters=0; min/arg contents need not be reset.

Configuration
REQ-033 Macro DISP_SCHED_COST_OUT_EN defined: extra output port out_cost (RW bits) carries min[out_blk] alongside each beat, same timing as out_disp.
REQ-034 Macro undefined: port out_cost absent and the min cost is used only internally for comparison; all other behaviour identical.

Verification
REQ-035 max_disp=3, CALC_LAT=2, all block costs constant 100 -> exactly 4 calc_sig pulses 68 cycles apart; all 64 out_disp=0 (tie rule).
REQ-036 Cost of block b = |disp_idx - (b mod 8)|*10, max_disp=7 -> out_disp[b]=b mod 8 for all 64 blocks; with COST_OUT_EN, out_cost=0.
REQ-037 out_ready toggled 1-0-0-1 repeating during OUT -> 64 beats in order 0..63, no duplicate or skipped block, beat stable while stalled; done one cycle after beat 63 accepted.
REQ-038 rst_n pulsed low during SCAN of disp_idx=2 -> busy, calc_sig, out_valid go 0 immediately; new start produces fresh sweep with first calc_sig 1 cycle after start.
REQ-039 start held high through a full sweep -> second sweep begins only after return to IDLE; start during busy has no effect on disp_idx or max_disp.
REQ-040 max_disp=0 with cost 0x3FFFF on all blocks -> one calc_sig, 64 beats with out_disp=0 (and out_cost=0x3FFFF when enabled).
